hermes_input_buffer: RTL and testbench
======================================

// Module: hermes_input_buffer
// PURPOSE
//  Per-port input stage of the Hermes router. Queues incoming flits in a credit-flow FIFO and raises req_o when a header flit is at the head.
//  Once the switch acks, it streams header, size and payload flits to the crossbar. sending_o marks the whole packet transfer.
//  One instance per port (HERMES_NPORT per router). req_o/sending_o/data_o feed the switch's req_i/sending_i/data_i.
// PARAMETERS
//  FLIT_SIZE    32  flit width in bits; minimum 20
//  BUFFER_SIZE  8   FIFO depth in flits; power of two, >= 2
// PORTS
//  clk_i      in   1          clock; everything is on the rising edge
//  rst_ni     in   1          reset, synchronous, active-low
//  rx_i       in   1          upstream flit valid
//  data_i     in   FLIT_SIZE  upstream flit
//  credit_o   out  1          space available; a flit is written when rx_i && credit_o
//  req_o      out  1          routing request to the switch (head flit = header)
//  ack_i      in   1          one-cycle grant pulse from the switch
//  sending_o  out  1          high from grant until the last flit is popped
//  tx_o       out  1          flit valid toward the crossbar
//  data_o     out  FLIT_SIZE  FIFO head flit, always driven, including during REQ
//  credit_i   in   1          downstream space; a flit is popped when tx_o && credit_i
// BEHAVIOUR
//  Reset (rst_ni low at a clock edge): FIFO emptied, pointers=0, count=0, state=IDLE.
//   After that edge: req_o=0, sending_o=0, tx_o=0, credit_o=1, data_o=don't care.
//   Reset mid-packet discards all stored flits and any remaining size count.
//  FIFO
//   credit_o = (count != BUFFER_SIZE), combinational from count.
//   Pointers wrap modulo BUFFER_SIZE; count is $clog2(BUFFER_SIZE)+1 bits wide.
//   Push and pop in the same cycle: count unchanged, both pointers advance.
//   When full, credit_o=0, so no push, even if a pop occurs in that cycle.
//   When empty, tx_o=0, so no pop; a push makes the flit visible on data_o next cycle (1-cycle fall-through).
//  FSM (hermes_buf_state_t): IDLE, REQ, HEADER, SIZE, PAYLOAD
//   IDLE:    all outputs 0. Go to REQ when count != 0.
//   REQ:     req_o=1. Head flit is held (no pop). On ack_i go to HEADER and set sending_o=1 (registered).
//   HEADER:  tx_o=1 (head present). On pop go to SIZE.
//   SIZE:    tx_o=!empty. On pop, load cnt = popped flit[HERMES_SIZE_W-1:0].
//            If that value is 0, go to IDLE and clear sending_o; otherwise go to PAYLOAD.
//   PAYLOAD: tx_o=!empty. On pop, cnt decrements. A pop with cnt==1 goes to IDLE and clears sending_o.
//  req_o, sending_o and tx_o are 0 in every state not listed for them.
//  sending_o falls the cycle after the last pop, so the switch releases the output port.
//  IDLE lasts at least 1 cycle between packets: sending_o is low >= 1 cycle and req_o for the next packet rises >= 1 cycle after sending_o falls.
//  ack_i outside REQ is ignored.
//  credit_i may drop at any cycle; the FSM stalls in place, no flit is lost or duplicated.
//  Ingress never stalls on FSM state; only FIFO full stops it.
// STRUCTURE
//  HermesPkg gains:
//   HERMES_SIZE_W = 16
//   typedef enum hermes_buf_state_t {IDLE, REQ, HEADER, SIZE, PAYLOAD}
//  Sub-module hermes_fifo #(FLIT_SIZE, BUFFER_SIZE): ports push/pop/data_in/data_out/full/empty; circular storage plus count.
//  Top level: FSM, size counter and output decode (~200 lines total).
// TESTING
//  1 Reset then idle: rst_ni=0 for 2 cycles -> credit_o=1, req_o=0, sending_o=0, tx_o=0.
//  2 Packet {0x0102, 0x0002, 0xA, 0xB}, credit_i=1, ack 3 cycles after req_o rises:
//    -> req_o held until ack; exactly 4 pops in order; sending_o falls 1 cycle after 0xB pops.
//  3 Fill test, credit_i=0, 10 flits offered: credit_o=0 after the 8th, flits 9-10 not written.
//    Then credit_i=1 -> all 8 drain in order.
//  4 Zero-size packet {0x0000, 0x0000} -> exactly 2 pops, back to IDLE.
//    A back-to-back second packet shows req_o low >= 1 cycle between packets.
//  5 credit_i toggling 1/0 each cycle over a 6-payload packet -> 8 pops total, no duplicate data_o values.
//    Then reset mid-PAYLOAD -> sending_o=0 and count=0 after the edge.

Source files
------------

// File: rtl/hermes_input_buffer_pkg.sv
// Shared types and constants for the Hermes router input buffer.
package hermes_input_buffer_pkg;

  localparam int HERMES_SIZE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HEADER,
    SIZE,
    PAYLOAD
  } hermes_buf_state_t;

endpackage

// File: rtl/hermes_fifo.sv
// Circular flit store with occupancy count; head flit is read combinationally.
module hermes_fifo
  import hermes_input_buffer_pkg::*;
#(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push,
  input  logic                 pop,
  input  logic [FLIT_SIZE-1:0] data_in,
  output logic [FLIT_SIZE-1:0] data_out,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  // Storage holds data only, so it is never cleared; the count decides validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == CNT_W'(BUFFER_SIZE));
  assign empty    = (count == '0);
  assign data_out = mem[rd_ptr];

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes router per-port input stage: credit-flow FIFO plus packet request/stream FSM.
module hermes_input_buffer
  import hermes_input_buffer_pkg::*;
#(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_o,
  input  logic                 ack_i,
  output logic                 sending_o,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i
);

  hermes_buf_state_t        state;
  logic [HERMES_SIZE_W-1:0] cnt;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;

  assign credit_o = !full;
  assign push     = rx_i && !full;
  assign tx_o     = (state == HEADER) ||
                    (((state == SIZE) || (state == PAYLOAD)) && !empty);
  assign pop      = tx_o && credit_i;

  hermes_fifo #(
    .FLIT_SIZE  (FLIT_SIZE),
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push),
    .pop     (pop),
    .data_in (data_i),
    .data_out(data_o),
    .full    (full),
    .empty   (empty)
  );

  // Leaving via IDLE after every packet guarantees a one-cycle gap before the next request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      req_o     <= 1'b0;
      sending_o <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= REQ;
            req_o <= 1'b1;
          end
        end
        REQ: begin
          if (ack_i) begin
            state     <= HEADER;
            req_o     <= 1'b0;
            sending_o <= 1'b1;
          end
        end
        HEADER: begin
          if (pop) begin
            state <= SIZE;
          end
        end
        SIZE: begin
          if (pop) begin
            cnt <= data_o[HERMES_SIZE_W-1:0];
            if (data_o[HERMES_SIZE_W-1:0] == '0) begin
              state     <= IDLE;
              sending_o <= 1'b0;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (pop) begin
            cnt <= cnt - 1'b1;
            if (cnt == HERMES_SIZE_W'(1)) begin
              state     <= IDLE;
              sending_o <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_o     <= 1'b0;
          sending_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Randomized bench for hermes_input_buffer against a packet-level queue model.
module tb_hermes_input_buffer;

  localparam int FLIT_SIZE   = 32;
  localparam int BUFFER_SIZE = 8;

  logic                 clk_i    = 1'b0;
  logic                 rst_ni   = 1'b0;
  logic                 rx_i     = 1'b0;
  logic [FLIT_SIZE-1:0] data_i   = '0;
  logic                 ack_i    = 1'b0;
  logic                 credit_i = 1'b0;
  logic                 credit_o;
  logic                 req_o;
  logic                 sending_o;
  logic                 tx_o;
  logic [FLIT_SIZE-1:0] data_o;

  always #5 clk_i = ~clk_i;

  hermes_input_buffer #(
    .FLIT_SIZE  (FLIT_SIZE),
    .BUFFER_SIZE(BUFFER_SIZE)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rx_i     (rx_i),
    .data_i   (data_i),
    .credit_o (credit_o),
    .req_o    (req_o),
    .ack_i    (ack_i),
    .sending_o(sending_o),
    .tx_o     (tx_o),
    .data_o   (data_o),
    .credit_i (credit_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: stored flits, packet progress, request phase.
  logic [31:0] q[$];
  logic [31:0] src[$];
  logic [31:0] popped[$];
  bit          m_req = 0;
  bit          m_pkt = 0;
  int          m_pos = 0;
  int          m_rem = 0;
  int          req_cnt = 0;
  int          ack_delay = 0;
  bit          spur_en = 0;
  bit          drop_mode = 0;
  bit          cr_toggle = 0;
  int          rx_pct = 100;
  int          cr_pct = 100;
  int          pops = 0;

  task automatic cycle(input bit rst_v);
    bit          push, pop, tx_exp, pkt_cur, req_cur;
    int          qs;
    logic [31:0] f;
    rst_ni = rst_v;
    rx_i   = (src.size() != 0) && ($urandom_range(99) < rx_pct);
    data_i = rx_i ? src[0] : $urandom;
    if (cr_toggle) credit_i = ~credit_i;
    else           credit_i = ($urandom_range(99) < cr_pct);
    if (m_req) ack_i = (req_cnt >= ack_delay);
    else       ack_i = spur_en && ($urandom_range(3) == 0);

    qs     = q.size();
    tx_exp = m_pkt && (qs != 0);
    check_val("credit_o", credit_o, qs != BUFFER_SIZE);
    check_val("req_o", req_o, m_req);
    check_val("sending_o", sending_o, m_pkt);
    check_val("tx_o", tx_o, tx_exp);
    push = rst_v && rx_i && (qs != BUFFER_SIZE);
    pop  = rst_v && tx_exp && credit_i;
    if (pop) check_val("data_o", data_o, q[0]);
    pkt_cur = m_pkt;
    req_cur = m_req;

    @(posedge clk_i);
    #1;
    if (!rst_v) begin
      q.delete();
      m_req = 0; m_pkt = 0; m_pos = 0; m_rem = 0; req_cnt = 0;
    end else begin
      if (pop) begin
        f = q.pop_front();
        pops++;
        popped.push_back(f);
        if (m_pos == 0) begin
          m_pos = 1;
        end else if (m_pos == 1) begin
          m_rem = int'(f[15:0]);
          if (m_rem == 0) m_pkt = 0;
          else m_pos = 2;
        end else begin
          m_rem--;
          if (m_rem == 0) m_pkt = 0;
        end
      end
      if (push) q.push_back(data_i);
      if (push || (drop_mode && rx_i)) void'(src.pop_front());
      if (req_cur) begin
        if (ack_i) begin
          m_req = 0; m_pkt = 1; m_pos = 0; req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else if (!pkt_cur && qs != 0) begin
        m_req = 1; req_cnt = 0;
      end
    end
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((src.size() != 0 || q.size() != 0 || m_req || m_pkt) && n < max) begin
      cycle(1'b1);
      n++;
    end
    check_val("drain_in_budget", n < max, 1);
    for (int i = 0; i < 3; i++) cycle(1'b1);
  endtask

  task automatic add_packet(input int len);
    logic [31:0] r;
    r = $urandom;
    src.push_back(r);
    r = $urandom;
    src.push_back({r[31:16], 16'(len)});
    for (int i = 0; i < len; i++) src.push_back($urandom);
  endtask

  initial begin
    int dups;
    // Test 1: reset held two edges, then idle.
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    cycle(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1);

    // Test 2: basic packet, ack three cycles after request.
    pops = 0; ack_delay = 3; cr_pct = 100; rx_pct = 100;
    src = '{32'h0102, 32'h0002, 32'h000A, 32'h000B};
    run_until_idle(100);
    check_val("t2_pops", pops, 4);

    // Test 3: fill with downstream blocked; two extra flits are refused.
    pops = 0; ack_delay = 0; cr_pct = 0; drop_mode = 1;
    src = '{32'h0300, 32'h0006, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h99, 32'h98};
    for (int i = 0; i < 12; i++) cycle(1'b1);
    check_val("t3_full_credit", credit_o, 0);
    drop_mode = 0; cr_pct = 100;
    run_until_idle(100);
    check_val("t3_pops", pops, 8);

    // Test 4: zero-size packets back to back.
    pops = 0; ack_delay = 1;
    src = '{32'h0000, 32'h0000, 32'h0401, 32'h0000};
    run_until_idle(100);
    check_val("t4_pops", pops, 4);

    // Test 5: toggling downstream credit, then reset in the middle of payload.
    pops = 0; popped.delete(); cr_toggle = 1; ack_delay = 2;
    src = '{32'h0500, 32'h0006, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26};
    run_until_idle(200);
    check_val("t5_pops", pops, 8);
    dups = 0;
    for (int i = 0; i < popped.size(); i++)
      for (int j = i + 1; j < popped.size(); j++)
        if (popped[i] == popped[j]) dups++;
    check_val("t5_unique", dups, 0);

    src = '{32'h0600, 32'h0006, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36};
    for (int n = 0; n < 200 && !(m_pkt && m_pos == 2); n++) cycle(1'b1);
    cycle(1'b1);
    src.delete();
    cycle(1'b0);
    check_val("t5_rst_sending", sending_o, 0);
    check_val("t5_rst_credit", credit_o, 1);
    cr_toggle = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1);

    // Random traffic: sizes, gaps, backpressure, ack delays, stray acks.
    spur_en = 1;
    for (int b = 0; b < 10; b++) begin
      rx_pct    = $urandom_range(100, 40);
      cr_pct    = $urandom_range(100, 30);
      ack_delay = $urandom_range(4);
      for (int p = 0; p < 4; p++) add_packet($urandom_range(5));
      run_until_idle(2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
